// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per cycle; drives the E-stage stall and the {HI,LO} result.
module div_iter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic                  i_clk,
   input  logic                  i_resetn,
   input  logic                  i_div_start,
   input  logic                  i_div_signed,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   input  logic                  i_cancel,
   output logic                  o_stall_divE,
   output logic                  o_div_ready,
   output logic [2*DATA_W-1:0]   o_result
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_dvs;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_quo;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_qneg;
   logic                r_rneg;
   logic [2*DATA_W-1:0] r_result;

   logic                w_a_neg;
   logic                w_b_neg;
   logic [DATA_W-1:0]   w_a_abs;
   logic [DATA_W-1:0]   w_b_abs;
   logic [DATA_W:0]     w_sh;
   logic                w_ge;
   logic [DATA_W-1:0]   w_rem_nx;
   logic [DATA_W-1:0]   w_quo_nx;
   logic [DATA_W-1:0]   w_lo;
   logic [DATA_W-1:0]   w_hi;
   logic                w_last;

   assign w_a_neg  = i_div_signed & i_a[DATA_W-1];
   assign w_b_neg  = i_div_signed & i_b[DATA_W-1];
   assign w_a_abs  = w_a_neg ? -i_a : i_a;
   assign w_b_abs  = w_b_neg ? -i_b : i_b;

   // The quotient register starts out holding the dividend; its MSB feeds the remainder.
   assign w_sh     = {r_rem, r_quo[DATA_W-1]};
   assign w_ge     = w_sh >= {1'b0, r_dvs};
   assign w_rem_nx = w_ge ? (w_sh[DATA_W-1:0] - r_dvs) : w_sh[DATA_W-1:0];
   assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};
   assign w_lo     = r_qneg ? -w_quo_nx : w_quo_nx;
   assign w_hi     = r_rneg ? -w_rem_nx : w_rem_nx;
   assign w_last   = r_cnt == CNT_W'(DATA_W-1);

   // Reset also gates the stall so every output is low while reset is held.
   assign o_stall_divE = i_resetn & i_div_start & ~i_cancel & (r_state != S_DONE);
   assign o_div_ready  = (r_state == S_DONE) & ~i_cancel;
   assign o_result     = r_result;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state  <= S_IDLE;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_cnt    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_div_start && !i_cancel) begin
                  r_quo  <= w_a_abs;
                  r_dvs  <= w_b_abs;
                  r_qneg <= w_a_neg ^ w_b_neg;
                  r_rneg <= w_a_neg;
                  r_rem  <= '0;
                  r_cnt  <= '0;
                  if (i_b == '0) begin
                     r_state  <= S_DONE;
                     r_result <= {i_a, {DATA_W{1'b1}}};
                  end else begin
                     r_state  <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (i_cancel || !i_div_start) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_state  <= S_DONE;
                     r_result <= {w_hi, w_lo};
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, corner sequences, random ops.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, sgn, cancel;
   logic [31:0] a, b;
   logic        stall, ready;
   logic [63:0] result;

   int total = 0;
   int bad   = 0;

   div_iter #(.DATA_W(32), .CNT_W(5)) dut (
      .i_clk(clk), .i_resetn(resetn), .i_div_start(start), .i_div_signed(sgn),
      .i_a(a), .i_b(b), .i_cancel(cancel),
      .o_stall_divE(stall), .o_div_ready(ready), .o_result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_res;
      int          exp_stall;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division with truncation toward zero.
   function automatic logic [63:0] model(input logic sg, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [31:0] lq, lr;
      if (y == 0) return {x, 32'hFFFF_FFFF};
      if (sg) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'({32'd0, x});
         sy = longint'({32'd0, y});
      end
      q  = sx / sy;
      r  = sx % sy;
      lq = q[31:0];
      lr = r[31:0];
      return {lr, lq};
   endfunction

   // Issue one op and hold div_start until div_ready; counts stall cycles.
   task automatic run_op(input string name, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp_res, input int exp_stall);
      int nstall;
      bit seen;
      nstall = 0;
      seen   = 0;
      @(negedge clk);
      start = 1'b1; sgn = s; a = x; b = y;
      #1;
      for (int c = 0; c < 100; c++) begin
         if (ready) begin
            seen = 1;
            check({name, " done_stall"}, 64'(stall), 64'd0);
            check({name, " result"}, result, exp_res);
            break;
         end
         if (stall) nstall++;
         @(negedge clk); #1;
      end
      start = 1'b0;
      check({name, " ready_seen"}, 64'(seen), 64'd1);
      check({name, " stall_cycles"}, 64'(nstall), 64'(exp_stall));
      @(negedge clk); #1;
      check({name, " ready_once"}, 64'(ready), 64'd0);
      check({name, " result_hold"}, result, exp_res);
   endtask

   vec_t vecs[6];

   initial begin
      logic [63:0] prev;
      logic [31:0] rx, ry;
      logic        rs;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},          33};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},   33};
      vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          {32'd1,          32'h7FFF_FFFC},   33};
      vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000},   33};
      vecs[4] = '{1'b0, 32'h0000_1234,  32'd0,          {32'h0000_1234,  32'hFFFF_FFFF},   1};
      vecs[5] = '{1'b1, 32'h0000_1234,  32'd0,          {32'h0000_1234,  32'hFFFF_FFFF},   1};

      resetn = 1'b0; start = 1'b0; sgn = 1'b0; cancel = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset result", result, 64'd0);
      check("reset ready", 64'(ready), 64'd0);
      check("reset stall", 64'(stall), 64'd0);
      resetn = 1'b1;

      for (int i = 0; i < 6; i++)
         run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_stall);

      // start with cancel in IDLE: no stall, nothing launched
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; a = 32'd5; b = 32'd1; sgn = 1'b0;
      #1;
      check("idle_cancel stall", 64'(stall), 64'd0);
      @(negedge clk); #1;
      check("idle_cancel ready", 64'(ready), 64'd0);
      start = 1'b0; cancel = 1'b0;

      // cancel on BUSY cycle 10
      prev = result;
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3;
      repeat (10) @(negedge clk);
      cancel = 1'b1;
      #1;
      check("cancel stall_low", 64'(stall), 64'd0);
      check("cancel ready_low", 64'(ready), 64'd0);
      @(negedge clk);
      cancel = 1'b0; start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (ready) check("cancel no_ready", 64'(ready), 64'd0);
         @(negedge clk);
      end
      check("cancel result_kept", result, prev);
      run_op("after_cancel", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

      // asynchronous reset mid-BUSY
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; a = 32'd77; b = 32'd4;
      repeat (12) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("arst result", result, 64'd0);
      check("arst stall", 64'(stall), 64'd0);
      check("arst ready", 64'(ready), 64'd0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      run_op("after_reset", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);

      // randomized ops against the reference model
      for (int i = 0; i < 25; i++) begin
         rs = 1'($urandom_range(0, 1));
         rx = $urandom;
         case ($urandom_range(0, 3))
            0:       ry = 32'($urandom_range(1, 15));
            1:       ry = -32'($urandom_range(1, 15));
            2:       ry = 32'd0;
            default: ry = $urandom;
         endcase
         run_op($sformatf("rnd%0d", i), rs, rx, ry, model(rs, rx, ry), (ry == 0) ? 1 : 33);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 divider serving DIV/DIVU in the execute stage.
- Produces the divide-busy stall (stall_divE) consumed by the hazard unit, and the {HI,LO} result written to the HI/LO registers.
- Holds the pipeline while busy: one quotient bit per cycle, early exit on divide-by-zero, abort on pipeline cancel.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == DATA_W.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- div_start  in  1  DIV/DIVU present in E; held high for as long as E is stalled.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start in IDLE.
- a  in  DATA_W  dividend (rs); sampled with div_start in IDLE.
- b  in  DATA_W  divisor (rt); sampled with div_start in IDLE.
- cancel  in  1  exception/flush of the E-stage instruction; aborts the operation.
- stall_divE  out  1  divider busy; stalls F/D/E. Combinational from state and inputs.
- div_ready  out  1  one-cycle pulse; result valid this cycle.
- result  out  2*DATA_W  {HI = remainder, LO = quotient}; registered.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, counter=0, result=0, div_ready=0, stall_divE=0.
  - Internal operand/remainder/quotient registers cleared.
  - Reset mid-operation discards all progress.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_start=1 & cancel=0: latch |a|, |b| (absolute values only when div_signed=1; otherwise raw values).
  - Also latch quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB], both forced 0 when unsigned.
  - Clear the partial remainder and counter.
  - b==0: go to DONE. Otherwise go to BUSY.
  - stall_divE=1 in this cycle.
- BUSY (restoring division, one bit per cycle):
  - Shift {rem,quo} left 1, bringing in the dividend MSB.
  - If rem ≥ divisor: subtract the divisor and set the quotient LSB to 1.
  - counter increments each cycle; leave BUSY after the cycle with counter==DATA_W-1, i.e. DATA_W BUSY cycles.
  - stall_divE=1 throughout.
- DONE:
  - stall_divE=0 and div_ready=1 for exactly one cycle.
  - result is loaded at the DONE entry edge, so it is already valid during DONE.
  - Next state is IDLE unconditionally.
  - The hazard unit releases E on this cycle; the instruction advances and div_start drops.
- Latency for a nonzero divisor: stall_divE high for 1+DATA_W = 33 consecutive cycles from the first div_start cycle; div_ready on cycle 34.
- Divide-by-zero:
  - stall_divE high for 1 cycle; DONE on the next.
  - result = {a, {DATA_W{1'b1}}} regardless of div_signed.
- Sign fix-up, applied when loading result:
  - LO = quotient sign ? −quo : quo.
  - HI = remainder sign ? −rem : rem.
  - Arithmetic is modulo 2^DATA_W.
- Overflow case (signed 0x80000000 / −1):
  - Natural wrap gives LO=0x80000000, HI=0.
  - No trap, no special-casing.
- cancel:
  - In any state, forces next state to IDLE and suppresses div_ready.
  - Gates stall_divE low in the same cycle: stall_divE = div_start & ~cancel & (state != DONE).
  - result is not updated on cancel.
- div_start=0 while BUSY (should not occur): treated as cancel.
- result holds its value until the next completed operation.
- No combinational path from result to stall_divE.

Test Plan:
- DIVU a=100, b=7:
  - stall_divE high exactly 33 cycles.
  - div_ready pulses once; result={32'd2, 32'd14}.
- DIV a=−7 (0xFFFFFFF9), b=2:
  - LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - Repeat as DIVU: LO=0x7FFFFFFC, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0, 33-cycle stall.
- b=0, a=0x1234:
  - stall_divE high for 1 cycle; div_ready next cycle.
  - result={0x00001234, 0xFFFFFFFF}.
- cancel asserted on BUSY cycle 10:
  - stall_divE low the same cycle, state IDLE next, no div_ready, result unchanged.
  - An immediate new div_start (DIVU 9/3) yields {0,3} after a full 33-cycle stall.
- resetn pulsed low mid-BUSY:
  - All outputs 0 asynchronously.
  - After release, a fresh DIVU 50/5 returns {0,10} with normal latency.
